// File: rtl/bool_lut_seq_if.sv
// ----------------------------------------------------------------------------
// bool_lut_seq_if : request/config/result signal bundle for bool_lut_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bool_lut_seq_if #(
   parameter int N_IN = 4
);
   logic              in_valid;
   logic [N_IN-1:0]   in_vec;
   logic              cfg_valid;
   logic              cfg_bit;
   logic              start;
   logic              out_valid;
   logic              f;
   logic              busy;
   logic              done;
   logic [N_IN:0]     ones_cnt;

   modport master (
      output in_valid, in_vec, cfg_valid, cfg_bit, start,
      input  out_valid, f, busy, done, ones_cnt
   );

   modport slave (
      input  in_valid, in_vec, cfg_valid, cfg_bit, start,
      output out_valid, f, busy, done, ones_cnt
   );
endinterface

`default_nettype wire

// File: rtl/bool_lut_seq.sv
// ----------------------------------------------------------------------------
// bool_lut_seq : N-input programmable LUT with serial table load and sweep
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bool_lut_seq #(
   parameter int                     N_IN    = 4,
   parameter logic [(1<<N_IN)-1:0]   TT_INIT = 16'h3F4C
) (
   input  logic         clk,
   input  logic         rst,
   bool_lut_seq_if.slave bus
);

   localparam int              c_TT_W    = 1 << N_IN;
   localparam logic [N_IN-1:0] c_LAST    = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] c_IDX_ONE = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [N_IN:0]   c_CNT_ONE = {{N_IN{1'b0}}, 1'b1};
   localparam logic [N_IN:0]   c_CNT_MAX = {(N_IN+1){1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SWEEP = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q,     state_d;
   logic [c_TT_W-1:0]   active_tt_q, active_tt_d;
   logic [c_TT_W-1:0]   shadow_q,    shadow_d;
   logic [N_IN-1:0]     cfg_cnt_q,   cfg_cnt_d;
   logic [N_IN-1:0]     sweep_cnt_q, sweep_cnt_d;
   logic [N_IN:0]       ones_cnt_q,  ones_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                f_q,         f_d;
   logic                done_q,      done_d;
   logic                w_sweep_bit;

   assign w_sweep_bit = active_tt_q[sweep_cnt_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         active_tt_q <= TT_INIT;
         shadow_q    <= '0;
         cfg_cnt_q   <= '0;
         sweep_cnt_q <= '0;
         ones_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         f_q         <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_tt_q <= active_tt_d;
         shadow_q    <= shadow_d;
         cfg_cnt_q   <= cfg_cnt_d;
         sweep_cnt_q <= sweep_cnt_d;
         ones_cnt_q  <= ones_cnt_d;
         out_valid_q <= out_valid_d;
         f_q         <= f_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      active_tt_d = active_tt_q;
      shadow_d    = shadow_q;
      cfg_cnt_d   = cfg_cnt_q;
      sweep_cnt_d = sweep_cnt_q;
      ones_cnt_d  = ones_cnt_q;
      out_valid_d = 1'b0;
      f_d         = f_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE, LOAD: begin
            // Evaluations always read the current table, so one issued on the
            // commit edge still sees the old contents.
            if (bus.in_valid) begin
               out_valid_d = 1'b1;
               f_d         = active_tt_q[bus.in_vec];
            end
            if (bus.cfg_valid) begin
               shadow_d = {bus.cfg_bit, shadow_q[c_TT_W-1:1]};
               if (cfg_cnt_q == c_LAST) begin
                  active_tt_d = shadow_d;
                  cfg_cnt_d   = '0;
                  state_d     = IDLE;
               end else begin
                  cfg_cnt_d   = cfg_cnt_q + c_IDX_ONE;
                  state_d     = LOAD;
               end
            end else if ((state_q == IDLE) && bus.start) begin
               state_d     = SWEEP;
               sweep_cnt_d = '0;
               ones_cnt_d  = '0;
            end
         end
         SWEEP: begin
            out_valid_d = 1'b1;
            f_d         = w_sweep_bit;
            if (w_sweep_bit && (ones_cnt_q != c_CNT_MAX)) begin
               ones_cnt_d = ones_cnt_q + c_CNT_ONE;
            end
            if (sweep_cnt_q == c_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               sweep_cnt_d = sweep_cnt_q + c_IDX_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.out_valid = out_valid_q;
   assign bus.f         = f_q;
   assign bus.busy      = (state_q == LOAD) || (state_q == SWEEP);
   assign bus.done      = done_q;
   assign bus.ones_cnt  = ones_cnt_q;

endmodule

`default_nettype wire

// File: doc/bool_lut_seq.md
BOOL_LUT_SEQ -- requirements
Module: bool_lut_seq

Interface
REQ-001 Parameter N_IN, default 4: number of function inputs, legal range 2..8.
REQ-002 Parameter TT_INIT, default 16'h3F4C: reset truth table, width 2**N_IN; bit k is the output for input index k. The default equals F = (U&!Z)|(!V&Z)|(!U&Z&!W) with index {U,V,Z,W}, U as MSB.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: evaluate request.
REQ-006 Port in_vec, input, N_IN: function input index.
REQ-007 Port cfg_valid, input, 1: serial truth-table bit strobe.
REQ-008 Port cfg_bit, input, 1: truth-table bit, sent LSB first (index 0 first).
REQ-009 Port start, input, 1: sweep request pulse.
REQ-010 Port out_valid, output, 1: f is valid this cycle.
REQ-011 Port f, output, 1: registered function result.
REQ-012 Port busy, output, 1: high in LOAD and SWEEP.
REQ-013 Port done, output, 1: one-cycle sweep-complete pulse.
REQ-014 Port ones_cnt, output, N_IN+1: number of 1 results in the last sweep.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SWEEP and DONE.
REQ-016 In IDLE or LOAD, in_valid=1 at edge T SHALL produce out_valid=1 and f=active_tt[in_vec] during cycle T+1 (latency 1).
REQ-017 out_valid SHALL be 0 in any cycle that is not produced by REQ-016 or REQ-020.
REQ-018 The first cfg_valid in IDLE SHALL enter LOAD; each cfg_valid SHALL shift cfg_bit into a shadow register and increment cfg_cnt.
REQ-019 When bit index 2**N_IN-1 is accepted, the shadow SHALL be copied to active_tt at that same edge, cfg_cnt SHALL clear to 0, and the FSM SHALL return to IDLE. Evaluations issued up to and including that edge SHALL use the old table.
REQ-020 start in IDLE SHALL enter SWEEP with sweep_cnt=0 and clear ones_cnt. Each SWEEP cycle SHALL evaluate index sweep_cnt and emit it at the next cycle with out_valid=1, in ascending order, one result per cycle with no gaps.
REQ-021 After index 2**N_IN-1 is issued, the FSM SHALL enter DONE. done=1 SHALL coincide with the last sweep out_valid, and ones_cnt SHALL already include that result. The FSM SHALL return to IDLE on the next edge.
REQ-022 ones_cnt SHALL hold its value until the next accepted start, and SHALL saturate at no value below 2**N_IN (full width N_IN+1).
REQ-023 start SHALL be ignored in LOAD, SWEEP and DONE. cfg_valid SHALL be ignored in SWEEP and DONE. in_valid SHALL be ignored in SWEEP and DONE.
REQ-024 When in_valid and start are both asserted in IDLE at the same edge, both SHALL be accepted: the eval result appears at T+1 and the first sweep result at T+2.
REQ-025 When cfg_valid and start are both asserted in IDLE at the same edge, cfg_valid SHALL win and start SHALL be dropped.
REQ-026 sweep_cnt SHALL stop at 2**N_IN-1 and SHALL not wrap to 0 within a sweep.

Reset
REQ-027 rst=1 SHALL immediately force: state=IDLE, active_tt=TT_INIT, shadow=0, cfg_cnt=0, sweep_cnt=0, out_valid=0, f=0, busy=0, done=0, ones_cnt=0.
REQ-028 A reset during LOAD SHALL discard the partial load with no commit.
REQ-029 A reset during SWEEP SHALL abort the sweep with no done pulse.
REQ-030 The first edge after rst deasserts SHALL accept requests normally.

Verification
REQ-031 Default table, eval: in_vec = 0..15 driven back-to-back -> f sequence is 0,0,1,1,0,0,1,0,1,1,1,1,1,1,0,0, each result one cycle after its request.
REQ-032 Sweep with the default table: start -> 16 consecutive out_valid cycles matching REQ-031, done on the 16th, ones_cnt=9, busy high throughout.
REQ-033 Load 16'h8001 (16 cfg_valid cycles), then eval in_vec=15, 0, 7 -> f = 1, 1, 0. An eval issued mid-load still returns the 0x3F4C value.
REQ-034 Assert rst after 7 load bits, then eval in_vec=2 -> f=1 (TT_INIT intact, no partial commit).
REQ-035 start and in_valid=1 with in_vec=8 at the same edge -> f=1 at T+1, sweep index 0 result at T+2. A start issued during SWEEP is ignored, giving exactly one done.
REQ-036 N_IN=2 with TT_INIT=4'b0110: sweep -> f = 0,1,1,0 and ones_cnt=2.
